// File: rtl/multimult_lane_acc.sv
// multimult_lane_acc
//   Lane accumulator behind the SIMD multiplier array. Each accepted beat
//   carries four signed lane partial sums (12/12/12/9 bits). The block
//   sign-extends them and adds them into four saturating ACC_W-bit
//   accumulators. After cfg_len beats it loads the four dot products into a
//   valid/ready output register. A cfg_len of 0 counts as 1.
//
// Ports
//   CLK, RST   clock, synchronous active-high reset
//   clr        abort the partial group; a pending result is untouched
//   cfg_len    beats per group, latched on the first beat of a group
//   in_valid   input beat handshake (with in_ready)
//   in_ready   low only while the output register is full and not draining
//   Y          packed lanes L0=Y[11:0] L1=Y[23:12] L2=Y[35:24] L3=Y[44:36]
//   out_valid  output handshake (with out_ready)
//   out_ready
//   out_data   lane n result in [n*ACC_W +: ACC_W]
//   out_ovf    per-lane saturation flag for the reported group
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no partial group; next accepted beat starts a new group
// S_ACCUM | group in progress; rem_q beats still to come

module multimult_lane_acc #(
   parameter int ACC_W = 20,
   parameter int CNT_W = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               clr,
   input  logic [CNT_W-1:0]   cfg_len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [44:0]        Y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*ACC_W-1:0] out_data,
   output logic [3:0]         out_ovf
);

   typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     rem_q, rem_d;
   logic signed [ACC_W-1:0] acc_q [4];
   logic signed [ACC_W-1:0] acc_d [4];
   logic [3:0]           ovf_q, ovf_d;
   logic                 out_valid_q, out_valid_d;
   logic [4*ACC_W-1:0]   out_data_q, out_data_d;
   logic [3:0]           out_ovf_q, out_ovf_d;

   logic signed [ACC_W:0]   lane_x [4];
   logic signed [ACC_W-1:0] base   [4];
   logic signed [ACC_W:0]   sum    [4];
   logic signed [ACC_W-1:0] sat_v  [4];
   logic [3:0]           clamp;
   logic [CNT_W-1:0]     len_eff;
   logic                 final_beat;
   logic                 accept;

   assign in_ready  = !RST && !(out_valid_q && !out_ready);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

   assign len_eff    = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
   assign final_beat = (state_q == S_IDLE) ? (len_eff == CNT_W'(1)) : (rem_q == CNT_W'(1));
   assign accept     = in_valid && in_ready && !clr;

   // One guard bit is enough: |lane| <= 2^11 <= 2^(ACC_W-1) since ACC_W >= 12.
   always_comb begin
      lane_x[0] = {{(ACC_W-11){Y[11]}}, Y[11:0]};
      lane_x[1] = {{(ACC_W-11){Y[23]}}, Y[23:12]};
      lane_x[2] = {{(ACC_W-11){Y[35]}}, Y[35:24]};
      lane_x[3] = {{(ACC_W-8){Y[44]}},  Y[44:36]};
      for (int n = 0; n < 4; n++) begin
         base[n]  = (state_q == S_ACCUM) ? acc_q[n] : '0;
         sum[n]   = {base[n][ACC_W-1], base[n]} + lane_x[n];
         clamp[n] = sum[n][ACC_W] ^ sum[n][ACC_W-1];
         if (clamp[n])
            sat_v[n] = sum[n][ACC_W] ? SAT_MIN : SAT_MAX;
         else
            sat_v[n] = sum[n][ACC_W-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;

      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      if (clr) begin
         state_d = S_IDLE;
         rem_d   = '0;
         ovf_d   = '0;
         for (int n = 0; n < 4; n++) acc_d[n] = '0;
      end else if (accept) begin
         if (final_beat) begin
            for (int n = 0; n < 4; n++) begin
               out_data_d[n*ACC_W +: ACC_W] = sat_v[n];
               acc_d[n] = '0;
            end
            out_ovf_d   = ((state_q == S_IDLE) ? 4'b0 : ovf_q) | clamp;
            out_valid_d = 1'b1;
            ovf_d       = '0;
            rem_d       = '0;
            state_d     = S_IDLE;
         end else begin
            acc_d   = sat_v;
            ovf_d   = ((state_q == S_IDLE) ? 4'b0 : ovf_q) | clamp;
            rem_d   = ((state_q == S_IDLE) ? len_eff : rem_q) - CNT_W'(1);
            state_d = S_ACCUM;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         ovf_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= '0;
         for (int n = 0; n < 4; n++) acc_q[n] <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         for (int n = 0; n < 4; n++) acc_q[n] <= acc_d[n];
      end
   end

endmodule

// File: tb/tb_multimult_lane_acc.sv
module tb_multimult_lane_acc;

   localparam int AW   = 16;
   localparam int CW   = 8;
   localparam int MAXV = 32767;
   localparam int MINV = -32768;

   logic          CLK = 1'b0;
   logic          RST;
   logic          clr;
   logic [CW-1:0] cfg_len;
   logic          in_valid;
   logic          in_ready;
   logic [44:0]   Y;
   logic          out_valid;
   logic          out_ready;
   logic [4*AW-1:0] out_data;
   logic [3:0]    out_ovf;

   multimult_lane_acc #(.ACC_W(AW), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .clr(clr), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .Y(Y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   int lv [4];

   // reference model: plain integer sums clamped per beat
   int       m_cnt;
   int       m_len;
   int       m_acc [4];
   bit [3:0] m_ovf;
   bit       m_full;
   int       m_data [4];
   bit [3:0] m_ovfo;

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic int lane(input int n);
      logic signed [AW-1:0] v;
      v = out_data[n*AW +: AW];
      return int'(v);
   endfunction

   task automatic set_lanes(input int a, input int b, input int c, input int d);
      lv[0] = a; lv[1] = b; lv[2] = c; lv[3] = d;
      Y = {9'(d), 12'(c), 12'(b), 12'(a)};
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_len  = 1;
      m_ovf  = '0;
      m_full = 1'b0;
      m_ovfo = '0;
      for (int n = 0; n < 4; n++) begin
         m_acc[n]  = 0;
         m_data[n] = 0;
      end
   endtask

   // called just after a falling edge with inputs already driven
   task automatic step();
      int  exp_rdy;
      bit  take;
      int  t;
      #1;
      exp_rdy = (m_full && !out_ready) ? 0 : 1;
      chk("in_ready", int'(in_ready), exp_rdy);
      chk("out_valid", int'(out_valid), int'(m_full));
      if (m_full) begin
         for (int n = 0; n < 4; n++) chk($sformatf("out_lane%0d", n), lane(n), m_data[n]);
         chk("out_ovf", int'(out_ovf), int'(m_ovfo));
      end

      take = in_valid && (exp_rdy == 1) && !clr;
      if (m_full && out_ready) m_full = 1'b0;
      if (take) begin
         if (m_cnt == 0) begin
            m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
            m_ovf = '0;
            for (int n = 0; n < 4; n++) m_acc[n] = 0;
         end
         for (int n = 0; n < 4; n++) begin
            t = m_acc[n] + lv[n];
            if (t > MAXV) begin t = MAXV; m_ovf[n] = 1'b1; end
            if (t < MINV) begin t = MINV; m_ovf[n] = 1'b1; end
            m_acc[n] = t;
         end
         m_cnt++;
         if (m_cnt == m_len) begin
            m_data = m_acc;
            m_ovfo = m_ovf;
            m_full = 1'b1;
            m_cnt  = 0;
            for (int n = 0; n < 4; n++) m_acc[n] = 0;
         end
      end
      if (clr) begin
         m_cnt = 0;
         m_ovf = '0;
         for (int n = 0; n < 4; n++) m_acc[n] = 0;
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic expect_out(input string tag, input int a, input int b,
                             input int c, input int d, input int ovf);
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_l0"}, lane(0), a);
      chk({tag, "_l1"}, lane(1), b);
      chk({tag, "_l2"}, lane(2), c);
      chk({tag, "_l3"}, lane(3), d);
      chk({tag, "_ovf"}, int'(out_ovf), ovf);
   endtask

   function automatic int rnd_lane(input int bits);
      int half;
      half = 1 << (bits - 1);
      case ($urandom_range(0, 7))
         0:       return -half;
         1:       return half - 1;
         default: return int'($urandom_range(0, 2*half - 1)) - half;
      endcase
   endfunction

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1; cfg_len = '0;
      set_lanes(0, 0, 0, 0);
      model_reset();
      repeat (3) begin
         @(posedge CLK); #1;
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_data_nz", int'(out_data != '0), 0);
         chk("rst_out_ovf", int'(out_ovf), 0);
      end
      @(negedge CLK);
      RST = 1'b0; in_valid = 1'b0;
      repeat (2) step();

      // basic group of three
      cfg_len = 3; in_valid = 1'b1; set_lanes(5, -3, 100, -1);
      repeat (3) step();
      in_valid = 1'b0;
      expect_out("basic", 15, -9, 300, -3, 0);
      step();

      // length 0 == 1, extreme lane values
      cfg_len = 0; in_valid = 1'b1; set_lanes(-2048, 2047, -1, -256);
      repeat (4) begin
         step();
         expect_out("len1", -2048, 2047, -1, -256, 0);
      end
      in_valid = 1'b0;
      repeat (2) step();

      // cfg_len changed mid-group is ignored
      cfg_len = 3; in_valid = 1'b1; set_lanes(1, 1, 1, 1);
      step();
      cfg_len = 5;
      step();
      chk("len_latch_early", int'(out_valid), 0);
      step();
      in_valid = 1'b0;
      expect_out("len_latch", 3, 3, 3, 3, 0);
      step();

      // backpressure
      cfg_len = 2; in_valid = 1'b1; set_lanes(10, -20, 30, -40);
      repeat (2) step();
      expect_out("bp_first", 20, -40, 60, -80, 0);
      out_ready = 1'b0; set_lanes(1, 2, 3, 4);
      repeat (3) begin
         step();
         chk("bp_stall_rdy", int'(in_ready), 0);
         expect_out("bp_hold", 20, -40, 60, -80, 0);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_rdy", int'(in_ready), 1);
      step();
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      expect_out("bp_second", 2, 4, 6, 8, 0);
      step();
      expect_out("bp_second_hold", 2, 4, 6, 8, 0);
      out_ready = 1'b1;
      repeat (2) step();

      // saturation
      cfg_len = 20; in_valid = 1'b1; set_lanes(2047, 0, 0, 0);
      repeat (20) step();
      in_valid = 1'b0;
      expect_out("sat_hi", 32767, 0, 0, 0, 1);
      step();
      cfg_len = 200; in_valid = 1'b1; set_lanes(0, 0, 0, -256);
      repeat (200) step();
      in_valid = 1'b0;
      expect_out("sat_lo", 0, 0, 0, -32768, 8);
      step();
      cfg_len = 2; in_valid = 1'b1; set_lanes(100, -100, 7, -7);
      repeat (2) step();
      in_valid = 1'b0;
      expect_out("sat_clear", 200, -200, 14, -14, 0);
      step();

      // clr aborts partial group
      cfg_len = 4; in_valid = 1'b1; set_lanes(1, 0, 0, 0);
      repeat (2) step();
      in_valid = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0; in_valid = 1'b1;
      repeat (3) step();
      chk("clr_no_early", int'(out_valid), 0);
      step();
      in_valid = 1'b0;
      expect_out("clr_abort", 4, 0, 0, 0, 0);
      step();

      // clr does not touch a pending result
      out_ready = 1'b0; cfg_len = 1; in_valid = 1'b1; set_lanes(-7, 8, -9, 10);
      step();
      in_valid = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0;
      expect_out("clr_pending", -7, 8, -9, 10, 0);
      out_ready = 1'b1;
      repeat (2) step();

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr       = ($urandom_range(0, 40) == 0);
         cfg_len   = CW'($urandom_range(0, 6));
         set_lanes(rnd_lane(12), rnd_lane(12), rnd_lane(12), rnd_lane(9));
         step();
      end
      in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
